// File: rtl/if_pc_predict.sv
// if_pc_predict: fetch PC register with a direct-mapped branch target buffer
// Latency: PC_IF is registered, so NPC_IF or actual_next appears on PC_IF one
//   cycle later. NPC_IF and redirect are combinational.
// Backpressure: bubbleF holds PC_IF. A redirect from EX takes priority over the
//   hold. BTB training from EX continues while IF is stalled.
//
// Optional feature: define BTB_2BIT_COUNTER_EN to add a 2-bit saturating
// counter per entry. Without it, every BTB hit predicts taken, and a not-taken
// branch that hits clears the entry's valid bit.
//
// Ports:
//   clk, rst_n      single clock; asynchronous active-low reset
//   bubbleF         hold the fetch PC (IF stall)
//   br_EX           a control-transfer instruction resolves in EX this cycle
//   taken_EX        actual outcome of that instruction
//   PC_EX           PC of the instruction in EX
//   target_EX       branch/jump target computed in EX
//   NPC_EX          next PC that was predicted for the instruction in EX
//   PC_IF           current fetch PC (registered)
//   NPC_IF          predicted next fetch PC (combinational)
//   redirect        mispredict in EX (combinational); used to flush IF/ID and ID/EX
module if_pc_predict #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ENTRY_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubbleF,
  input  logic        br_EX,
  input  logic        taken_EX,
  input  logic [31:0] PC_EX,
  input  logic [31:0] target_EX,
  input  logic [31:0] NPC_EX,
  output logic [31:0] PC_IF,
  output logic [31:0] NPC_IF,
  output logic        redirect
);

  localparam int NUM_ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W       = 30 - ENTRY_BITS;

  // Storage for the BTB. Only the valid bits and the counters are reset.
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag    [NUM_ENTRIES];
  logic [31:0]            r_target [NUM_ENTRIES];
`ifdef BTB_2BIT_COUNTER_EN
  logic [1:0]             r_cnt    [NUM_ENTRIES];
`endif

  logic [31:0] r_pc;

  logic [ENTRY_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic                  w_if_hit;
  logic                  w_if_pred_taken;
  logic [ENTRY_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]      w_ex_tag;
  logic                  w_ex_hit;
  logic [31:0]           w_actual_next;

  // Lookup in the IF stage. The lookup reads the registered array, so an EX
  // write to the same entry in this cycle is visible only after the edge.
  assign w_if_idx = PC_IF[ENTRY_BITS+1:2];
  assign w_if_tag = PC_IF[31:ENTRY_BITS+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

`ifdef BTB_2BIT_COUNTER_EN
  assign w_if_pred_taken = w_if_hit && r_cnt[w_if_idx][1];
`else
  assign w_if_pred_taken = w_if_hit;
`endif

  assign NPC_IF = w_if_pred_taken ? r_target[w_if_idx] : (PC_IF + 32'd4);

  // Resolve the branch in EX. The tag match uses the pre-write contents.
  assign w_ex_idx      = PC_EX[ENTRY_BITS+1:2];
  assign w_ex_tag      = PC_EX[31:ENTRY_BITS+2];
  assign w_ex_hit      = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_actual_next = taken_EX ? target_EX : (PC_EX + 32'd4);
  assign redirect      = br_EX && (w_actual_next != NPC_EX);

  // Fetch PC register: redirect, then hold, then follow the prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc <= w_actual_next;
    end else if (!bubbleF) begin
      r_pc <= NPC_IF;
    end
  end

  assign PC_IF = r_pc;

  // Valid bits and counters. A not-taken branch that misses the BTB does not
  // allocate an entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
`ifdef BTB_2BIT_COUNTER_EN
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_cnt[i] <= 2'b00;
      end
`endif
    end else if (br_EX) begin
      if (taken_EX) begin
        r_valid[w_ex_idx] <= 1'b1;
`ifdef BTB_2BIT_COUNTER_EN
        if (!w_ex_hit) begin
          r_cnt[w_ex_idx] <= 2'b10;
        end else if (r_cnt[w_ex_idx] != 2'b11) begin
          r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] + 2'd1;
        end
`endif
      end else if (w_ex_hit) begin
`ifdef BTB_2BIT_COUNTER_EN
        if (r_cnt[w_ex_idx] != 2'b00) begin
          r_cnt[w_ex_idx] <= r_cnt[w_ex_idx] - 2'd1;
        end
`else
        r_valid[w_ex_idx] <= 1'b0;
`endif
      end
    end
  end

  // Tag and target storage has no reset. It is written only on a taken branch.
  // A hit rewrites the same tag, so no hit check is needed here.
  always_ff @(posedge clk) begin
    if (rst_n && br_EX && taken_EX) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= target_EX;
    end
  end

endmodule

// File: tb/tb_if_pc_predict.sv
// Directed bench for if_pc_predict using hand-computed expectations.
module tb_if_pc_predict;

  logic        clk;
  logic        rst_n;
  logic        bubbleF;
  logic        br_EX;
  logic        taken_EX;
  logic [31:0] PC_EX;
  logic [31:0] target_EX;
  logic [31:0] NPC_EX;
  logic [31:0] PC_IF;
  logic [31:0] NPC_IF;
  logic        redirect;

  int n_checks = 0;
  int n_fail   = 0;

  if_pc_predict #(.RESET_PC(32'h0000_0000), .ENTRY_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bubbleF   (bubbleF),
    .br_EX     (br_EX),
    .taken_EX  (taken_EX),
    .PC_EX     (PC_EX),
    .target_EX (target_EX),
    .NPC_EX    (NPC_EX),
    .PC_IF     (PC_IF),
    .NPC_IF    (NPC_IF),
    .redirect  (redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    br_EX = 1'b0; taken_EX = 1'b0; PC_EX = '0; target_EX = '0; NPC_EX = '0;
  endtask

  task automatic ex_branch(input logic tk, input logic [31:0] pc,
                           input logic [31:0] tgt, input logic [31:0] npc);
    br_EX = 1'b1; taken_EX = tk; PC_EX = pc; target_EX = tgt; NPC_EX = npc;
  endtask

  // Force a fetch from addr with a not-taken branch at addr-4 whose predicted
  // next PC was 0. No BTB entry is allocated by this branch.
  task automatic goto_pc(input logic [31:0] addr);
    ex_branch(1'b0, addr - 32'd4, 32'h0, 32'h0);
    #1;
    tick();
    ex_idle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; bubbleF = 1'b0;
    ex_idle();
    #2;
    // Reset state and combinational behaviour while in reset
    check("rst_pc", PC_IF, 32'h0);
    check("rst_npc", NPC_IF, 32'h4);
    check("rst_redirect0", {31'b0, redirect}, 32'h0);
    ex_branch(1'b1, 32'h0, 32'h100, 32'h4);
    #1;
    check("rst_redirect_comb", {31'b0, redirect}, 32'h1);
    tick();
    check("rst_pc_held", PC_IF, 32'h0);
    ex_idle();
    rst_n = 1'b1;
    #1;
    check("rel_pc0", PC_IF, 32'h0);
    check("rel_npc0", NPC_IF, 32'h4);

    // Sequential fetch with no branches
    tick(); check("seq_pc4", PC_IF, 32'h4);
    tick(); check("seq_pc8", PC_IF, 32'h8);
    tick(); check("seq_pcC", PC_IF, 32'hC);
    check("seq_npc10", NPC_IF, 32'h10);
    check("seq_redirect", {31'b0, redirect}, 32'h0);
    tick(); check("seq_pc10", PC_IF, 32'h10);

    // Stall for three cycles
    bubbleF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_hold", PC_IF, 32'h10);
    end
    bubbleF = 1'b0;
    tick(); check("stall_resume", PC_IF, 32'h14);

    // br_EX=0 forces redirect low even when the other EX inputs mismatch
    br_EX = 1'b0; taken_EX = 1'b1; PC_EX = 32'h100; target_EX = 32'h200; NPC_EX = 32'h0;
    #1;
    check("no_br_redirect", {31'b0, redirect}, 32'h0);
    ex_idle();

    // First taken branch at 0x20 to 0x80
    ex_branch(1'b1, 32'h20, 32'h80, 32'h24);
    #1;
    check("br_redirect", {31'b0, redirect}, 32'h1);
    tick(); check("br_pc80", PC_IF, 32'h80);
    ex_idle();
    goto_pc(32'h20);
    check("goto_20", PC_IF, 32'h20);
    check("btb_hit_npc", NPC_IF, 32'h80);
    tick(); check("follow_pred", PC_IF, 32'h80);

`ifdef BTB_2BIT_COUNTER_EN
    // Taken again (counter 11, predicted correctly), then not taken twice (10, 01)
    ex_branch(1'b1, 32'h20, 32'h80, 32'h80);
    #1;
    check("cnt_taken2_noredir", {31'b0, redirect}, 32'h0);
    tick();
    ex_branch(1'b0, 32'h20, 32'h80, 32'h80);
    #1;
    check("cnt_nt1_redir", {31'b0, redirect}, 32'h1);
    tick(); check("cnt_nt1_pc24", PC_IF, 32'h24);
    ex_idle();
    goto_pc(32'h20);
    check("cnt_10_still_taken", NPC_IF, 32'h80);
    ex_branch(1'b0, 32'h20, 32'h80, 32'h80);
    #1;
    tick();
    ex_idle();
    goto_pc(32'h20);
    check("cnt_01_not_taken", NPC_IF, 32'h24);
`else
    // A not-taken hit invalidates the entry
    ex_branch(1'b0, 32'h20, 32'h80, 32'h80);
    #1;
    check("nt_redir", {31'b0, redirect}, 32'h1);
    tick(); check("nt_pc24", PC_IF, 32'h24);
    ex_idle();
    goto_pc(32'h20);
    check("nt_invalidated", NPC_IF, 32'h24);
`endif

    // 0x20 is cached again; 0x60 aliases to the same index with a different tag
    ex_branch(1'b1, 32'h20, 32'h80, 32'h24);
    #1;
    tick();
    ex_idle();
    goto_pc(32'h60);
    check("alias_miss", NPC_IF, 32'h64);

    // Update and lookup of the same entry in one cycle: lookup sees old contents
    ex_branch(1'b1, 32'h60, 32'hA0, 32'hA0);
    #1;
    check("same_cyc_noredir", {31'b0, redirect}, 32'h0);
    check("same_cyc_old_npc", NPC_IF, 32'h64);
    tick(); check("same_cyc_pc64", PC_IF, 32'h64);
    ex_idle();
    goto_pc(32'h60);
    check("alias_new_hit", NPC_IF, 32'hA0);

    // redirect has priority over bubbleF
    bubbleF = 1'b1;
    ex_branch(1'b1, 32'h30, 32'h40, 32'h34);
    #1;
    tick(); check("redir_over_bubble", PC_IF, 32'h40);
    bubbleF = 1'b0;
    ex_idle();

    // Address wrap
    goto_pc(32'hFFFF_FFFC);
    check("wrap_npc", NPC_IF, 32'h0);
    tick(); check("wrap_pc", PC_IF, 32'h0);

    // Reset pulse between edges takes effect immediately and empties the BTB
    tick(); check("pre_rst_pc", PC_IF, 32'h4);
    rst_n = 1'b0;
    #1;
    check("rst_pulse_pc", PC_IF, 32'h0);
    check("rst_pulse_npc", NPC_IF, 32'h4);
    rst_n = 1'b1;
    #1;
    tick(); check("post_rst_pc4", PC_IF, 32'h4);
    goto_pc(32'h60);
    check("post_rst_btb_empty", NPC_IF, 32'h64);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  // Upper bound on simulation time
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_pc_predict.md
IF_PC_PREDICT -- requirements
Module: if_pc_predict

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter ENTRY_BITS, default 4, log2 of BTB entry count (16 entries).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port bubbleF  input  1  hold PC (IF stall).
REQ-006 SHALL have port br_EX  input  1  control-transfer instruction resolved in EX this cycle.
REQ-007 SHALL have port taken_EX  input  1  actual branch outcome in EX.
REQ-008 SHALL have port PC_EX  input  32  PC of the instruction in EX.
REQ-009 SHALL have port target_EX  input  32  computed branch/jump target in EX.
REQ-010 SHALL have port NPC_EX  input  32  predicted next PC carried down the pipeline for the EX instruction.
REQ-011 SHALL have port PC_IF  output  32  current fetch PC, registered.
REQ-012 SHALL have port NPC_IF  output  32  predicted next PC, combinational from PC_IF and BTB.
REQ-013 SHALL have port redirect  output  1  mispredict in EX, combinational; hazard unit uses it to flush IF/ID and ID/EX.

Function
REQ-014 SHALL index the BTB with PC_IF[ENTRY_BITS+1:2] and tag it with PC_IF[31:ENTRY_BITS+2]; each entry: valid, tag, 32-bit target, 2-bit counter.
REQ-015 SHALL flag a hit when the indexed entry is valid and its tag equals the PC_IF tag.
REQ-016 SHALL drive NPC_IF = stored target when hit and predict-taken (REQ-033/034), else PC_IF+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-017 SHALL compute actual_next = taken_EX ? target_EX : PC_EX+4.
REQ-018 SHALL assert redirect = br_EX & (actual_next != NPC_EX); redirect SHALL be 0 when br_EX=0.
REQ-019 SHALL update PC_IF each edge with priority: redirect -> actual_next; else bubbleF -> hold; else NPC_IF.
REQ-020 SHALL give redirect priority over bubbleF when both are asserted in the same cycle.
REQ-021 SHALL update the BTB on an edge with br_EX=1, indexed/tagged by PC_EX, independent of bubbleF.
REQ-022 On taken_EX=1 with tag miss (invalid or different tag), the BTB SHALL write valid=1, tag, target_EX, counter=2'b10.
REQ-023 On taken_EX=1 with tag hit, the BTB SHALL write target_EX and increment the counter, saturating at 2'b11.
REQ-024 On taken_EX=0 with tag hit, the BTB SHALL decrement the counter, saturating at 2'b00; the entry SHALL stay valid.
REQ-025 On taken_EX=0 with tag miss, the BTB SHALL do nothing (no allocation).
REQ-026 When EX update and IF lookup hit the same entry in one cycle, lookup SHALL see pre-update contents (write takes effect at the edge).
REQ-027 PC_IF latency SHALL be one cycle from NPC_IF/actual_next to PC_IF; no output SHALL be combinationally driven from its own register input.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately set PC_IF=RESET_PC, all valid bits=0 and all counters=2'b00, regardless of clk.
REQ-029 While rst_n=0, the block SHALL ignore BTB writes and PC updates; NPC_IF SHALL equal RESET_PC+4.
REQ-030 Reset deassertion mid-operation SHALL restart fetch at RESET_PC with an empty BTB on the first following edge.
REQ-031 Target and tag storage SHALL need no reset; only valid bits and counters are reset.
REQ-032 redirect SHALL follow its inputs combinationally during reset.

Configuration
REQ-033 With macro BTB_2BIT_COUNTER_EN defined, the block SHALL predict taken on hit only when counter[1]=1.
REQ-034 Without BTB_2BIT_COUNTER_EN, the block SHALL omit counter storage, predict taken on every hit, and on a not-taken tag hit SHALL clear the entry's valid bit instead of decrementing.

Verification
REQ-035 Reset then release, no branches -> PC_IF sequence 0,4,8,C; NPC_IF = PC_IF+4; redirect=0.
REQ-036 bubbleF=1 for 3 cycles at PC_IF=0x10 -> PC_IF holds 0x10, then resumes 0x14.
REQ-037 Branch at 0x20 target 0x80, first taken (NPC_EX=0x24) -> redirect=1, next PC_IF=0x80; next fetch of 0x20 -> NPC_IF=0x80.
REQ-038 (EN defined) Same branch taken twice, then not taken twice -> counter 10,11,10,01; third fetch of 0x20 -> NPC_IF=0x24.
REQ-039 (EN undefined) Taken then not taken at 0x20 -> entry invalidated; next fetch NPC_IF=0x24.
REQ-040 redirect and bubbleF together with actual_next=0x40; aliasing PCs 0x20/0x60 with ENTRY_BITS=4; rst_n pulse between edges -> PC_IF=0x40; 0x60 misses; PC_IF=RESET_PC immediately.
